// File: rtl/pwm_pkg.sv
// pwm_pkg: frame constants and decoder state shared by the PWM generator and decoder
package pwm_pkg;
    localparam int PWM_WIDTH  = 8;
    localparam int PWM_PERIOD = 256;
    typedef enum logic {IDLE, TRACK} pwm_state_e;
endpackage

// File: rtl/pwm_decoder_if.sv
// pwm_decoder_if: PWM line in, decoded frame data and status out
interface pwm_decoder_if
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
);
    logic             pwm_in;
    logic [WIDTH-1:0] data;
    logic             data_valid;
    logic             locked;
    logic             period_err;
    logic             stuck_err;
    modport master (output pwm_in, input data, data_valid, locked, period_err, stuck_err);
    modport slave  (input pwm_in, output data, data_valid, locked, period_err, stuck_err);
endinterface

// File: rtl/pwm_sync_edge.sv
// pwm_sync_edge: multi-flop synchronizer for an async line plus rising-edge detect
module pwm_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_i,
    output logic pwm_s_o,
    output logic rise_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pwm_d_q;
    // shift the raw line through the synchronizer and keep one extra delayed copy
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            pwm_d_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_i};
            pwm_d_q <= sync_q[SYNC_STAGES-1];
        end
    end
    assign pwm_s_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = pwm_s_o & ~pwm_d_q;
endmodule

// File: rtl/pwm_decoder.sv
// pwm_decoder: measures the high time of each PWM frame and flags framing errors
module pwm_decoder
    import pwm_pkg::*;
#(
    parameter int WIDTH       = PWM_WIDTH,
    parameter int PERIOD      = PWM_PERIOD,
    parameter int SYNC_STAGES = 2
) (
    input logic          clk,
    input logic          rst,
    pwm_decoder_if.slave bus
);
    localparam logic [WIDTH:0] PER = (WIDTH+1)'(PERIOD);
    localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);
    pwm_state_e       state_q;
    logic [WIDTH:0]   per_cnt_q, per_cnt_d, hi_cnt_q, hi_cnt_d;
    logic [WIDTH-1:0] data_q;
    logic             data_valid_q, locked_q, period_err_q, stuck_err_q;
    logic             pwm_s, rise, at_period, timeout, boundary;
    logic             unused_hi_msb;
    pwm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .pwm_i  (bus.pwm_in),
        .pwm_s_o(pwm_s),
        .rise_o (rise)
    );
    assign at_period     = per_cnt_q == PER;
    assign timeout       = !rise && at_period;
    assign boundary      = rise || timeout;
    assign unused_hi_msb = hi_cnt_q[WIDTH];
    // a boundary restarts both counters; a rise counts its own high sample
    always_comb begin
        per_cnt_d = boundary ? ONE : per_cnt_q + ONE;
        hi_cnt_d  = boundary ? {{WIDTH{1'b0}}, rise} : hi_cnt_q + {{WIDTH{1'b0}}, pwm_s};
    end
    // frame and high-time counters
    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
        end else begin
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
        end
    end
    // alignment FSM; a timeout with the line low is a duty-0 frame, not an error
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            period_err_q <= 1'b0;
            stuck_err_q  <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            period_err_q <= 1'b0;
            stuck_err_q  <= 1'b0;
            if (state_q == IDLE) begin
                if (rise || (timeout && !pwm_s)) begin
                    state_q  <= TRACK;
                    locked_q <= 1'b1;
                end else if (timeout) begin
                    stuck_err_q <= 1'b1;
                end
            end else if (rise) begin
                if (at_period) begin
                    data_q       <= hi_cnt_q[WIDTH-1:0];
                    data_valid_q <= 1'b1;
                end else begin
                    period_err_q <= 1'b1;
                    locked_q     <= 1'b0;
                    state_q      <= IDLE;
                end
            end else if (timeout) begin
                if (!pwm_s) begin
                    data_q       <= hi_cnt_q[WIDTH-1:0];
                    data_valid_q <= 1'b1;
                end else begin
                    stuck_err_q <= 1'b1;
                    locked_q    <= 1'b0;
                    state_q     <= IDLE;
                end
            end
        end
    end
    assign bus.data       = data_q;
    assign bus.data_valid = data_valid_q;
    assign bus.locked     = locked_q;
    assign bus.period_err = period_err_q;
    assign bus.stuck_err  = stuck_err_q;
endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder: generator model drives the decoder; reports checked against a scoreboard queue
module tb_pwm_decoder;
    localparam int PERIOD = 256;
    logic clk = 1'b0;
    logic rst = 1'b1;
    pwm_decoder_if #(.WIDTH(8)) bus ();
    pwm_decoder #(.WIDTH(8), .PERIOD(PERIOD), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    typedef struct {
        bit rst_first;
        int data;
        int frames;
        int exp_perr;
        int exp_stuck;
        bit exp_locked;
    } vec_t;
    vec_t vecs[7];
    int   q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_perr = 0;
    int   n_stuck = 0;
    int   gen_cnt = 0;
    int   prev_data = 0;
    bit   prev_valid = 0;
    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask
    task automatic tick(input logic p, input logic r);
        int exp;
        @(negedge clk);
        bus.pwm_in = p;
        rst = r;
        @(posedge clk);
        #1;
        n_cmp++;
        if (int'(bus.data_valid) + int'(bus.period_err) + int'(bus.stuck_err) > 1) begin
            n_fail++;
            $display("FAIL exclusive: dv=%0b perr=%0b stuck=%0b, expected at most one", bus.data_valid, bus.period_err, bus.stuck_err);
        end
        n_perr += int'(bus.period_err);
        n_stuck += int'(bus.stuck_err);
        if (bus.data_valid) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_dv: data_valid with data=%0d, expected no report", bus.data);
            end else begin
                exp = q.pop_front();
                if (int'(bus.data) != exp) begin
                    n_fail++;
                    $display("FAIL data: got %0d, expected %0d", bus.data, exp);
                end
            end
        end
    endtask
    task automatic gen_cycle(input int d, input int g);
        logic line;
        if (gen_cnt == 0) begin
            if (prev_valid) q.push_back(prev_data);
            prev_data = d;
            prev_valid = 1;
        end
        line = (gen_cnt < d) || (g >= 0 && gen_cnt >= g && gen_cnt < g + 3);
        tick(line, 1'b0);
        gen_cnt = (gen_cnt + 1) % PERIOD;
    endtask
    task automatic run_frames(input int d, input int n, input int g);
        for (int i = 0; i < n * PERIOD; i++) gen_cycle(d, g);
    endtask
    task automatic do_reset();
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
        q.delete();
        prev_valid = 0;
        gen_cnt = 0;
    endtask
    initial begin
        bus.pwm_in = 1'b0;
        vecs[0] = '{1, 0,   4, 0, 0, 1};
        vecs[1] = '{1, 100, 4, 0, 0, 1};
        vecs[2] = '{0, 0,   3, 0, 0, 1};
        vecs[3] = '{0, 255, 3, 0, 0, 1};
        vecs[4] = '{0, 1,   3, 0, 0, 1};
        vecs[5] = '{0, 128, 3, 0, 0, 1};
        vecs[6] = '{0, 100, 3, 0, 0, 1};
        do_reset();
        chk("reset_data", int'(bus.data), 0);
        chk("reset_locked", int'(bus.locked), 0);
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].rst_first) do_reset();
            n_perr = 0;
            n_stuck = 0;
            run_frames(vecs[v].data, vecs[v].frames, -1);
            chk($sformatf("row%0d_perr", v), n_perr, vecs[v].exp_perr);
            chk($sformatf("row%0d_stuck", v), n_stuck, vecs[v].exp_stuck);
            chk($sformatf("row%0d_locked", v), int'(bus.locked), int'(vecs[v].exp_locked));
            chk($sformatf("row%0d_pending_le1", v), int'(q.size() <= 1), 1);
        end
        n_perr = 0;
        n_stuck = 0;
        run_frames(40, 3, -1);
        run_frames(40, 1, 50);
        prev_valid = 0;
        chk("glitch_perr", n_perr, 1);
        chk("glitch_locked", int'(bus.locked), 0);
        chk("glitch_data_held", int'(bus.data), 40);
        run_frames(40, 3, -1);
        chk("glitch_relock", int'(bus.locked), 1);
        chk("glitch_perr_total", n_perr, 1);
        run_frames(100, 2, -1);
        n_perr = 0;
        n_stuck = 0;
        if (prev_valid) q.push_back(prev_data);
        prev_valid = 0;
        for (int i = 0; i < 600; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
        chk("stuck_count", n_stuck, 2);
        chk("stuck_perr", n_perr, 0);
        chk("stuck_locked", int'(bus.locked), 0);
        chk("stuck_no_pending", q.size(), 0);
        gen_cnt = 0;
        run_frames(100, 3, -1);
        chk("stuck_relock", int'(bus.locked), 1);
        for (int i = 0; i < 150; i++) gen_cycle(100, -1);
        tick(1'b0, 1'b1);
        gen_cnt++;
        q.delete();
        prev_valid = 0;
        chk("rst_data", int'(bus.data), 0);
        chk("rst_dv", int'(bus.data_valid), 0);
        chk("rst_locked", int'(bus.locked), 0);
        chk("rst_perr", int'(bus.period_err), 0);
        chk("rst_stuck", int'(bus.stuck_err), 0);
        n_perr = 0;
        n_stuck = 0;
        while (gen_cnt != 0) gen_cycle(100, -1);
        run_frames(100, 2, -1);
        for (int i = 0; i < 10; i++) gen_cycle(100, -1);
        chk("rst_relock", int'(bus.locked), 1);
        chk("rst_reported", q.size(), 0);
        chk("rst_perr_after", n_perr, 0);
        chk("rst_data_after", int'(bus.data), 100);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
